// File: rtl/floor_call_scheduler_pkg.sv
// Shared definitions for the floor-call scheduler: floor geometry, FSM encoding and the
// shortened debounce length used in simulation builds.
package floor_call_scheduler_pkg;

  localparam int unsigned NumFloors   = 4;
  localparam int unsigned FloorW      = 2;
  localparam int unsigned DbCyclesSim = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StOffer = 2'd1,
    StBusy  = 2'd2
  } sched_state_e;

endpackage

// File: rtl/floor_call_scheduler_if.sv
// Scheduler <-> motion-core link: target offer handshake plus car position/arrival feedback.
interface floor_call_scheduler_if #(
  parameter int unsigned FW = 2
) ();

  logic [FW-1:0] cur_floor;
  logic          arrived;
  logic          target_ready;
  logic          target_valid;
  logic [FW-1:0] target_floor;
  logic          dir_up;
  logic          busy;

  // Scheduler side.
  modport master (
    input  cur_floor, arrived, target_ready,
    output target_valid, target_floor, dir_up, busy
  );

  // Motion-core side.
  modport slave (
    output cur_floor, arrived, target_ready,
    input  target_valid, target_floor, dir_up, busy
  );

endinterface

// File: rtl/floor_call_scheduler_sw_debounce.sv
// One call switch: 2-FF synchroniser, stable-sample debounce counter and rising-edge pulse.
module floor_call_scheduler_sw_debounce
  import floor_call_scheduler_pkg::*;
#(
  parameter int unsigned DB_CYCLES  = 100000,
  parameter bit          SIMULATION = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_i,
  output logic level_o,
  output logic rise_o
);

  localparam int unsigned DbCount = SIMULATION ? DbCyclesSim : DB_CYCLES;
  localparam int unsigned CntW    = (DbCount > 1) ? $clog2(DbCount) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DbCount - 1);

  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic            rise_q, rise_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Count consecutive samples that disagree with the debounced level; adopt after DbCount.
  always_comb begin
    level_d = level_q;
    rise_d  = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CntMax) begin
        level_d = sync2_q;
        rise_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Synchroniser, counter and registered level/rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sw_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/floor_call_scheduler.sv
// Elevator call scheduler: latches debounced floor calls, picks the next floor in SCAN
// order and offers it to the motion core over a valid/ready handshake.
module floor_call_scheduler
  import floor_call_scheduler_pkg::*;
#(
  parameter int unsigned NUM_FLOORS = NumFloors,
  parameter int unsigned FW         = FloorW,
  parameter int unsigned DB_CYCLES  = 100000,
  parameter bit          SIMULATION = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] sw_i,
  output logic [NUM_FLOORS-1:0] pending_o,
  floor_call_scheduler_if.master core_io
);

  localparam int NF = int'(NUM_FLOORS);

  logic [NUM_FLOORS-1:0] sw_level, sw_rise;
  logic [NUM_FLOORS-1:0] pending_q, pending_d;
  sched_state_e          state_q;
  logic                  target_valid_q, busy_q, dir_up_q;
  logic [FW-1:0]         target_floor_q;

  logic                  cur_valid;
  int                    cur_int;
  logic                  up_found, dn_found, sel_found, sel_dir;
  logic [FW-1:0]         up_idx, dn_idx, sel_floor;

  // Debounced levels are not used here; only the call events matter.
  logic unused_sw_level;
  assign unused_sw_level = ^sw_level;

  for (genvar g = 0; g < NF; g++) begin : g_db
    floor_call_scheduler_sw_debounce #(
      .DB_CYCLES  (DB_CYCLES),
      .SIMULATION (SIMULATION)
    ) u_db (
      .clk     (clk),
      .rst     (rst),
      .sw_i    (sw_i[g]),
      .level_o (sw_level[g]),
      .rise_o  (sw_rise[g])
    );
  end

  assign cur_int   = int'(core_io.cur_floor);
  assign cur_valid = (cur_int < NF);

  // Nearest pending floor above and below the car; out-of-range cur_floor finds nothing.
  always_comb begin
    up_found = 1'b0;
    up_idx   = '0;
    dn_found = 1'b0;
    dn_idx   = '0;
    if (cur_valid) begin
      for (int i = NF - 1; i >= 0; i--) begin
        if (pending_q[i] && (i > cur_int)) begin
          up_found = 1'b1;
          up_idx   = FW'(i);
        end
      end
      for (int i = 0; i < NF; i++) begin
        if (pending_q[i] && (i < cur_int)) begin
          dn_found = 1'b1;
          dn_idx   = FW'(i);
        end
      end
    end
  end

  // SCAN choice: keep direction while calls lie ahead, else reverse. A lone call at the
  // car's own floor (latched while busy) is served in place so it cannot stick.
  always_comb begin
    sel_found = 1'b0;
    sel_floor = '0;
    sel_dir   = dir_up_q;
    if (dir_up_q ? up_found : dn_found) begin
      sel_found = 1'b1;
      sel_floor = dir_up_q ? up_idx : dn_idx;
    end else if (dir_up_q ? dn_found : up_found) begin
      sel_found = 1'b1;
      sel_floor = dir_up_q ? dn_idx : up_idx;
      sel_dir   = ~dir_up_q;
    end else if (cur_valid && pending_q[core_io.cur_floor]) begin
      sel_found = 1'b1;
      sel_floor = core_io.cur_floor;
    end
  end

  // Pending calls: arrival clears and beats a same-cycle call; idle calls to the car's floor drop.
  always_comb begin
    pending_d = pending_q;
    for (int i = 0; i < NF; i++) begin
      if (sw_rise[i] && !((state_q == StIdle) && cur_valid && (cur_int == i))) begin
        pending_d[i] = 1'b1;
      end
    end
    if (core_io.arrived && cur_valid) begin
      pending_d[core_io.cur_floor] = 1'b0;
    end
  end

  // Pending register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // Handshake FSM with registered outputs; target and direction freeze once offered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      target_valid_q <= 1'b0;
      target_floor_q <= '0;
      dir_up_q       <= 1'b1;
      busy_q         <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (sel_found) begin
            target_floor_q <= sel_floor;
            dir_up_q       <= sel_dir;
            target_valid_q <= 1'b1;
            state_q        <= StOffer;
          end
        end
        StOffer: begin
          if (core_io.target_ready) begin
            target_valid_q <= 1'b0;
            busy_q         <= 1'b1;
            state_q        <= StBusy;
          end
        end
        StBusy: begin
          if (core_io.arrived) begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: begin
          target_valid_q <= 1'b0;
          busy_q         <= 1'b0;
          state_q        <= StIdle;
        end
      endcase
    end
  end

  assign pending_o            = pending_q;
  assign core_io.target_valid = target_valid_q;
  assign core_io.target_floor = target_floor_q;
  assign core_io.dir_up       = dir_up_q;
  assign core_io.busy         = busy_q;

endmodule
